// File: rtl/issue_queue_alloc_pkg.sv
// Shared sizing constants and pointer type for the 16-entry oldest-first issue queue.
package issue_queue_alloc_pkg;
  localparam int IQ_DEPTH = 16;
  localparam int IQ_IDX_W = 4;
  localparam int IQ_PTR_W = 5;  // index bits plus one wrap bit

  typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
endpackage

// File: rtl/iq_ptr_ctrl.sv
// Top/bottom wrap-bit pointers of the issue queue window, with full detection
// and in-order reclaim of at most one freed bottom slot per cycle.
module iq_ptr_ctrl
  import issue_queue_alloc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic                alloc_fire_i,
  input  logic [IQ_DEPTH-1:0] occupied_i,
  output logic [IQ_IDX_W-1:0] top_idx_o,
  output logic [IQ_IDX_W-1:0] bot_idx_o,
  output logic                full_o
);

  iq_ptr_t top_q;
  iq_ptr_t bot_q;
  logic    empty;
  logic    reclaim;

  assign empty  = (top_q == bot_q);
  assign full_o = (top_q[IQ_IDX_W-1:0] == bot_q[IQ_IDX_W-1:0]) &&
                  (top_q[IQ_PTR_W-1] != bot_q[IQ_PTR_W-1]);

  // Holes above the bottom are left in place; only the oldest slot is reclaimed.
  assign reclaim = !empty && !occupied_i[bot_q[IQ_IDX_W-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      top_q <= '0;
      bot_q <= '0;
    end else if (flush_i) begin
      top_q <= '0;
      bot_q <= '0;
    end else begin
      if (alloc_fire_i) top_q <= top_q + iq_ptr_t'(1);
      if (reclaim)      bot_q <= bot_q + iq_ptr_t'(1);
    end
  end

  assign top_idx_o = top_q[IQ_IDX_W-1:0];
  assign bot_idx_o = bot_q[IQ_IDX_W-1:0];

endmodule

// File: rtl/issue_queue_alloc.sv
// Entry storage for a 16-entry oldest-first issue queue: in-order allocation,
// wakeup, issue of the externally selected entry, and a zero-cycle payload mux.
module issue_queue_alloc
  import issue_queue_alloc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic                alloc_vld_i,
  input  logic                alloc_rdy_i,
  input  logic [DATA_W-1:0]   alloc_data_i,
  output logic                alloc_rdy_o,
  output logic [IQ_IDX_W-1:0] alloc_idx_o,
  input  logic                wakeup_vld_i,
  input  logic [IQ_IDX_W-1:0] wakeup_idx_i,
  output logic [DEPTH-1:0]    valid_array_o,
  output logic [IQ_IDX_W-1:0] bottom_ptr_o,
  input  logic [IQ_IDX_W-1:0] issue_ptr_i,
  output logic                issue_vld_o,
  output logic [DATA_W-1:0]   issue_data_o,
  input  logic                issue_rdy_i
);

  logic [DEPTH-1:0]    occupied_q;
  logic [DEPTH-1:0]    ready_q;
  logic [DEPTH-1:0]    occupied_next;
  logic [DEPTH-1:0]    ready_next;
  logic [DEPTH-1:0]    alloc_hit;
  logic [DEPTH-1:0]    wake_hit;
  logic [DEPTH-1:0]    issue_hit;
  logic [DATA_W-1:0]   payload_q [DEPTH];
  logic [IQ_IDX_W-1:0] top_idx;
  logic                full;
  logic                alloc_fire;
  logic                issue_fire;

  iq_ptr_ctrl u_ptr_ctrl (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flush_i      (flush_i),
    .alloc_fire_i (alloc_fire),
    .occupied_i   (occupied_q),
    .top_idx_o    (top_idx),
    .bot_idx_o    (bottom_ptr_o),
    .full_o       (full)
  );

  assign alloc_rdy_o = !full;
  assign alloc_idx_o = top_idx;
  assign alloc_fire  = alloc_vld_i && !full && !flush_i;
  assign issue_fire  = issue_vld_o && issue_rdy_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign alloc_hit[gi] = alloc_fire && (top_idx == IQ_IDX_W'(gi));
      // Wakeup only lands on a live entry; a slot being allocated is never live.
      assign wake_hit[gi]  = wakeup_vld_i && occupied_q[gi] &&
                             (wakeup_idx_i == IQ_IDX_W'(gi));
      assign issue_hit[gi] = issue_fire && (issue_ptr_i == IQ_IDX_W'(gi));
    end
  endgenerate

  // Issue has the last word so a same-cycle wakeup cannot re-ready a freed entry.
  assign occupied_next = (occupied_q | alloc_hit) & ~issue_hit;
  assign ready_next    = (((ready_q | wake_hit) & ~alloc_hit) |
                          (alloc_hit & {DEPTH{alloc_rdy_i}})) & ~issue_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occupied_q <= '0;
      ready_q    <= '0;
    end else if (flush_i) begin
      occupied_q <= '0;
      ready_q    <= '0;
    end else begin
      occupied_q <= occupied_next;
      ready_q    <= ready_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_fire) payload_q[top_idx] <= alloc_data_i;
  end

  assign valid_array_o = occupied_q & ready_q;
  assign issue_vld_o   = |valid_array_o;
  assign issue_data_o  = payload_q[issue_ptr_i];

  always_ff @(posedge clk_i) begin
    if (rst_n_i && issue_fire) assert (valid_array_o[issue_ptr_i]);
  end

endmodule

// File: tb/tb_issue_queue_alloc.sv
// Scoreboard bench for issue_queue_alloc: directed scenarios plus random traffic
// against a count-based window model; a monitor compares every cycle.
module tb_issue_queue_alloc;
  import issue_queue_alloc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        alloc_vld = 1'b0;
  logic        alloc_rdy_in = 1'b0;
  logic [31:0] alloc_data = '0;
  logic        alloc_rdy_out;
  logic [3:0]  alloc_idx;
  logic        wakeup_vld = 1'b0;
  logic [3:0]  wakeup_idx = '0;
  logic [15:0] valid_array;
  logic [3:0]  bottom_ptr;
  logic [3:0]  issue_ptr = '0;
  logic        issue_vld;
  logic [31:0] issue_data;
  logic        issue_rdy = 1'b0;

  issue_queue_alloc #(.DEPTH(16), .DATA_W(32)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .flush_i       (flush),
    .alloc_vld_i   (alloc_vld),
    .alloc_rdy_i   (alloc_rdy_in),
    .alloc_data_i  (alloc_data),
    .alloc_rdy_o   (alloc_rdy_out),
    .alloc_idx_o   (alloc_idx),
    .wakeup_vld_i  (wakeup_vld),
    .wakeup_idx_i  (wakeup_idx),
    .valid_array_o (valid_array),
    .bottom_ptr_o  (bottom_ptr),
    .issue_ptr_i   (issue_ptr),
    .issue_vld_o   (issue_vld),
    .issue_data_o  (issue_data),
    .issue_rdy_i   (issue_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ar;
    logic [3:0]  ai;
    logic [15:0] va;
    logic [3:0]  bp;
    bit          iv;
    logic [31:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;

  // Reference model: window as [head, tail) in unbounded allocation counts.
  bit          m_occ [16];
  bit          m_rdy [16];
  logic [31:0] m_pl  [16];
  int          m_head = 0;
  int          m_tail = 0;

  function automatic logic [15:0] m_valid();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_occ[i] && m_rdy[i];
    return v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) begin
      m_occ[i] = 1'b0;
      m_rdy[i] = 1'b0;
    end
    m_head = 0;
    m_tail = 0;
  endfunction

  function automatic exp_t m_expect(input logic [3:0] ip);
    exp_t e;
    e.ar = (m_tail - m_head) != 16;
    e.ai = 4'(m_tail % 16);
    e.va = m_valid();
    e.bp = 4'(m_head % 16);
    e.iv = |e.va;
    e.id = m_pl[ip];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, required %h", name, cycle_no, act, req);
    end
  endtask

  // Monitor: samples 2 time units after each falling edge, once inputs are settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cycle_no++;
        chk("alloc_rdy", 32'(alloc_rdy_out), 32'(e.ar));
        chk("alloc_idx", 32'(alloc_idx), 32'(e.ai));
        chk("valid_array", 32'(valid_array), 32'(e.va));
        chk("bottom_ptr", 32'(bottom_ptr), 32'(e.bp));
        chk("issue_vld", 32'(issue_vld), 32'(e.iv));
        if (e.iv) chk("issue_data", issue_data, e.id);
        $display("cyc %0d: va=%h bp=%0d ai=%0d ar=%0b iv=%0b", cycle_no,
                 valid_array, bottom_ptr, alloc_idx, alloc_rdy_out, issue_vld);
      end
    end
  end

  task automatic step(input bit f, input bit av, input bit ar, input logic [31:0] ad,
                      input bit wv, input logic [3:0] wi, input logic [3:0] ip,
                      input bit ir);
    exp_t e;
    bit   afire;
    bit   ifire;
    bit   reclaim;
    int   slot;
    @(negedge clk);
    flush = f; alloc_vld = av; alloc_rdy_in = ar; alloc_data = ad;
    wakeup_vld = wv; wakeup_idx = wi; issue_ptr = ip; issue_rdy = ir;
    e = m_expect(ip);
    exp_q.push_back(e);
    if (f) begin
      m_clear();
    end else begin
      afire   = av && e.ar;
      ifire   = e.iv && ir;
      reclaim = (m_tail != m_head) && !m_occ[m_head % 16];
      if (wv && m_occ[wi]) m_rdy[wi] = 1'b1;
      if (afire) begin
        slot = m_tail % 16;
        m_occ[slot] = 1'b1;
        m_rdy[slot] = ar;
        m_pl[slot]  = ad;
        m_tail++;
      end
      if (ifire) begin
        m_occ[ip] = 1'b0;
        m_rdy[ip] = 1'b0;
      end
      if (reclaim) m_head++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic alloc(input bit ar, input logic [31:0] ad);
    step(0, 1, ar, ad, 0, '0, '0, 0);
  endtask

  task automatic issue(input logic [3:0] ip);
    step(0, 0, 0, '0, 0, '0, ip, 1);
  endtask

  task automatic do_flush();
    step(1, 0, 0, '0, 0, '0, '0, 0);
  endtask

  // Asserted on a falling edge, well away from any rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 0; alloc_vld = 0; wakeup_vld = 0; issue_rdy = 0;
    m_clear();
    exp_q.push_back(m_expect(issue_ptr));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(m_expect(issue_ptr));
  endtask

  function automatic logic [3:0] pick_valid(output bit found);
    int cand[$];
    for (int i = 0; i < 16; i++) if (m_occ[i] && m_rdy[i]) cand.push_back(i);
    found = cand.size() > 0;
    if (!found) return 4'($urandom_range(15));
    return 4'(cand[$urandom_range(cand.size() - 1)]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    logic [3:0]  ip;
    m_clear();
    for (int i = 0; i < 16; i++) m_pl[i] = '0;
    do_reset();
    idle(1);

    // Fill to full, then one ignored request.
    for (int i = 0; i < 16; i++) alloc(1, 32'h100 + i);
    alloc(1, 32'hDEAD);
    idle(1);

    // Hole at 5 does not move bottom; freeing 0 does.
    issue(4'd5);
    idle(1);
    issue(4'd0);
    idle(2);
    alloc(1, 32'h200);
    alloc(1, 32'h201);
    idle(2);

    // Not-ready allocation and wakeup.
    do_flush();
    for (int i = 0; i < 3; i++) alloc(0, 32'h300 + i);
    idle(1);
    step(0, 0, 0, '0, 1, 4'd1, '0, 0);
    idle(1);
    issue(4'd1);
    idle(2);

    // Wrap-around at index 14.
    do_flush();
    for (int i = 0; i < 14; i++) alloc(1, 32'h400 + i);
    for (int i = 0; i < 14; i++) issue(4'(i));
    idle(4);
    for (int i = 0; i < 4; i++) alloc(1, 32'h500 + i);
    issue(4'd14);
    issue(4'd15);
    issue(4'd0);
    issue(4'd1);
    idle(6);

    // Same-cycle wakeup/issue to 3, wakeup to unoccupied 9.
    do_flush();
    for (int i = 0; i < 5; i++) alloc(0, 32'h600 + i);
    step(0, 0, 0, '0, 1, 4'd3, '0, 0);
    step(0, 0, 0, '0, 1, 4'd3, 4'd3, 1);
    idle(1);
    step(0, 0, 0, '0, 1, 4'd9, '0, 0);
    idle(2);

    // Flush with live entries beats a concurrent allocation.
    do_flush();
    for (int i = 0; i < 7; i++) alloc(i[0], 32'h700 + i);
    step(1, 1, 1, 32'h7FF, 0, '0, '0, 0);
    idle(2);

    // Random traffic, with one asynchronous reset midway.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      ip = pick_valid(found);
      step($urandom_range(99) == 0, $urandom_range(99) < 55, 1'($urandom_range(1)),
           $urandom, $urandom_range(99) < 40, 4'($urandom_range(15)), ip,
           found && ($urandom_range(99) < 45));
    end
    idle(3);

    @(negedge clk);
    #3;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
